// File: rtl/mpu_pkg.sv
// mpu_pkg: shared constants and types for the matrix unit operand path.
// Used by the scratchpad tile reader and its output FIFO.
package mpu_pkg;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

    typedef logic [DEF_LANES-1:0][7:0] lane_vec_t;
endpackage

// File: rtl/spad_tile_reader_vec_fifo2.sv
// vec_fifo2: two-entry valid/ready FIFO for packed vectors.
// Carries vector data plus end-of-row and end-of-tile flags.
module vec_fifo2
    import mpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_eor,
    input  logic         i_last,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_eor,
    output logic         o_last,
    output logic [1:0]   o_cnt
);
    logic [W+1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign o_valid = (r_cnt != 2'd0);
    assign w_pop   = i_pop & o_valid;
    assign o_cnt   = r_cnt;
    assign {o_eor, o_last, o_data} = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= {i_eor, i_last, i_data};
                r_wr        <= ~r_wr;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/spad_tile_reader.sv
// spad_tile_reader: streams an int8 tile from scratchpad into LANES-wide vectors.
// Define SPAD_TILE_READER_PERF_EN to add the stall_cycles counter port.
module spad_tile_reader
    import mpu_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    stride,
    input  logic [7:0]           rows,
    input  logic [7:0]           cols,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    spad_addr,
    input  logic [7:0]           spad_dout,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [8*LANES-1:0]   vec_data,
    output logic                 vec_eor,
    output logic                 vec_last
`ifdef SPAD_TILE_READER_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int LW = $clog2(LANES);

    rd_state_t                r_state;
    logic [ADDR_W-1:0]        r_row_base;
    logic [ADDR_W-1:0]        r_stride;
    logic [7:0]               r_rows;
    logic [7:0]               r_cols;
    logic [7:0]               r_col;
    logic [7:0]               r_row;
    logic                     r_iss;
    logic                     r_rd_vld;
    logic                     r_rd_eov;
    logic                     r_rd_eor;
    logic                     r_rd_last;
    logic [LW-1:0]            r_rd_lane;
    logic [LANES-1:0][7:0]    r_pack;

    logic [LANES-1:0][7:0]    w_vec;
    logic                     w_eor;
    logic                     w_lrow;
    logic                     w_last;
    logic [LW-1:0]            w_lane;
    logic                     w_eov;
    logic [1:0]               w_inflt;
    logic [1:0]               w_cnt;
    logic                     w_can_issue;
    logic                     w_push;
    logic                     w_pop;
    logic [7:0]               w_nxt_col;
    logic [7:0]               w_nxt_row;
    logic [ADDR_W-1:0]        w_nxt_base;
    logic [ADDR_W-1:0]        w_nxt_addr;

    // Flags of the element currently presented on spad_addr.
    assign w_eor  = (r_col == r_cols - 8'd1);
    assign w_lrow = (r_row == r_rows - 8'd1);
    assign w_last = w_eor & w_lrow;
    assign w_lane = r_col[LW-1:0];
    assign w_eov  = (&w_lane) | w_eor;

    // Vectors already promised to the FIFO by bytes still on their way back.
    assign w_inflt     = {1'b0, r_iss & w_eov} + {1'b0, r_rd_vld & r_rd_eov};
    assign w_can_issue = ({1'b0, w_cnt} + {1'b0, w_inflt}) < 3'd2;
    assign w_push      = r_rd_vld & r_rd_eov;
    assign w_pop       = vec_valid & vec_ready;

    always_comb begin
        w_vec            = r_pack;
        w_vec[r_rd_lane] = spad_dout;
    end

    always_comb begin
        w_nxt_col  = r_col + 8'd1;
        w_nxt_row  = r_row;
        w_nxt_base = r_row_base;
        if (w_eor) begin
            w_nxt_col  = 8'd0;
            w_nxt_row  = r_row + 8'd1;
            w_nxt_base = r_row_base + r_stride;
        end
    end

    assign w_nxt_addr = w_nxt_base + ADDR_W'(w_nxt_col);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            spad_addr  <= '0;
            r_row_base <= '0;
            r_stride   <= '0;
            r_rows     <= 8'd0;
            r_cols     <= 8'd0;
            r_col      <= 8'd0;
            r_row      <= 8'd0;
            r_iss      <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_eov   <= 1'b0;
            r_rd_eor   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_lane  <= '0;
            r_pack     <= '0;
        end else begin
            done      <= 1'b0;
            r_rd_vld  <= r_iss;
            r_rd_eov  <= w_eov;
            r_rd_eor  <= w_eor;
            r_rd_last <= w_last;
            r_rd_lane <= w_lane;
            if (w_push)
                r_pack <= '0;
            else if (r_rd_vld)
                r_pack <= w_vec;

            unique case (r_state)
                IDLE: begin
                    r_iss <= 1'b0;
                    if (start) begin
                        if (rows != 8'd0 && cols != 8'd0) begin
                            r_state    <= RUN;
                            busy       <= 1'b1;
                            r_rows     <= rows;
                            r_cols     <= cols;
                            r_stride   <= stride;
                            r_row_base <= base_addr;
                            spad_addr  <= base_addr;
                            r_col      <= 8'd0;
                            r_row      <= 8'd0;
                            r_iss      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DRAIN;
                        r_iss   <= 1'b0;
                    end else if (w_can_issue) begin
                        r_col      <= w_nxt_col;
                        r_row      <= w_nxt_row;
                        r_row_base <= w_nxt_base;
                        spad_addr  <= w_nxt_addr;
                        r_iss      <= 1'b1;
                    end else begin
                        r_iss <= 1'b0;
                    end
                end
                DRAIN: r_iss <= 1'b0;
                default: begin
                    r_state <= IDLE;
                    r_iss   <= 1'b0;
                end
            endcase

            if (r_state != IDLE && w_pop && vec_last) begin
                r_state <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    vec_fifo2 #(
        .W (8*LANES)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_vec),
        .i_eor   (r_rd_eor),
        .i_last  (r_rd_last),
        .i_pop   (vec_ready),
        .o_valid (vec_valid),
        .o_data  (vec_data),
        .o_eor   (vec_eor),
        .o_last  (vec_last),
        .o_cnt   (w_cnt)
    );

`ifdef SPAD_TILE_READER_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (!rst)
            r_stall <= '0;
        else if (r_state == IDLE && start)
            r_stall <= '0;
        else if (r_state != IDLE && vec_valid && !vec_ready && !(&r_stall))
            r_stall <= r_stall + 32'd1;
    end

    assign stall_cycles = r_stall;
`endif
endmodule

// File: doc/spad_tile_reader.md
# spad_tile_reader

Streams a rectangular int8 tile out of the byte-wide scratchpad RAM and packs it into LANES-wide vectors for the matrix array's operand input. Sits directly downstream of the scratchpad: it drives the RAM read address every cycle and consumes its 1-cycle-latency `dout`. Produces a valid/ready vector stream with row and tile boundary flags, with full backpressure and no lost or duplicated bytes.

## Interface
- `LANES`, 4: int8 lanes per output vector (power of two, 2..16).
- `ADDR_W`, 16: scratchpad address width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: launch a tile read; sampled only in IDLE.
- `base_addr` in ADDR_W: address of element (0,0); captured on accepted `start`.
- `stride` in ADDR_W: byte distance between row starts; captured on `start`.
- `rows` in 8: tile rows; captured on `start`.
- `cols` in 8: tile columns (bytes per row); captured on `start`.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle pulse at tile completion.
- `spad_addr` out ADDR_W: scratchpad read address.
- `spad_dout` in 8: scratchpad read data, valid one cycle after its address.
- `vec_valid` out 1: output vector valid.
- `vec_ready` in 1: consumer accepts.
- `vec_data` out 8*LANES: lane i in bits [8i+7:8i]; lane 0 = lowest address.
- `vec_eor` out 1: vector is last of its row.
- `vec_last` out 1: vector is last of the tile.

## Operation
- States: IDLE, RUN, DRAIN. IDLE→RUN on `start` with rows≠0 and cols≠0. IDLE→done pulse (stay IDLE) on `start` with rows=0 or cols=0. RUN→DRAIN after last address issued. DRAIN→IDLE when the `vec_last` vector handshakes; `done` asserts that next cycle.
- `start` while busy is ignored; parameters latched at acceptance are immune to later input changes.
- Address generation: `spad_addr = row_base + col`; `row_base += stride` at end of each row; all sums mod 2^ADDR_W (wrap, no error).
- Each row splits into ceil(cols/LANES) vectors; a row never shares a vector with the next. Tail lanes beyond `cols` are zero.
- Packing register collects one byte per cycle; a complete vector moves into a 2-entry output FIFO.
- Issue rule: a new address is issued only if FIFO occupancy plus vectors completing from bytes in flight is < 2; otherwise `spad_addr` holds and the col/row counters do not advance. Stall never drops the in-flight byte.
- `vec_data`, `vec_eor`, `vec_last` stable while `vec_valid` and not `vec_ready`.
- Block never writes the scratchpad.

## Timing
- Reset values: `busy`=0, `done`=0, `vec_valid`=0, `vec_data`=0, `vec_eor`=0, `vec_last`=0, `spad_addr`=0; FIFO and pack register cleared.
- Reset mid-operation: same cycle-after effect as above; no `done`; partial tile discarded.
- `start` accepted at edge t: `busy`=1 and first address driven from t+1; byte 0 captured at t+2.
- First vector `vec_valid` earliest at t+LANES+2 (t+6 for LANES=4) with `vec_ready` held high.
- Sustained throughput with `vec_ready`=1: one byte/cycle, one vector per LANES cycles, plus one idle cycle per row only when cols is not a multiple of LANES... none otherwise.
- `done` pulses the cycle after the `vec_last` handshake; `busy` falls in that same cycle.

## Configuration
- `SPAD_TILE_READER_PERF_EN` defined: adds output `stall_cycles` (32 bits) counting RUN/DRAIN cycles with `vec_valid`&~`vec_ready`; cleared on reset and on accepted `start`; saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `mpu_pkg`: `LANES`, `ADDR_W` defaults, `rd_state_t` enum (IDLE, RUN, DRAIN), vector typedef `lane_vec_t` (LANES × int8).
- One sub-module: `vec_fifo2`, 2-entry valid/ready FIFO carrying data plus `eor`/`last` flags.

## Test plan
- RAM bytes 0..15 = 0x10..0x1F; base 0, stride 4, rows 2, cols 4, ready=1 → vectors 0x13121110 (eor) and 0x17161514 (eor, last); `done` the cycle after the second handshake.
- cols 6, rows 1, base 0 → 0x13121110 then 0x00001514 (eor, last); addresses 0..5 only.
- rows 3, cols 8, ready low for 10 cycles mid-stream → 6 vectors, exact byte order, `spad_addr` frozen during stall, no duplicates.
- base 0xFFFE, rows 1, cols 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rows 0, `start` at t → `done` at t+1, `vec_valid` never asserts, `busy` stays 0.
- `rst`=0 after second vector of a 4-row tile → all outputs zero next cycle, no `done`; new `start` then completes normally.
